// File: rtl/cnn_conv_pkg.sv
// Shared CNN convolution helpers: window element indexing, kernel legality,
// counter sizing and default geometry.
package cnn_conv_pkg;

  localparam int unsigned DEF_KERNEL = 3;
  localparam int unsigned DEF_N      = 4;
  localparam int unsigned DEF_IMG_W  = 8;
  localparam int unsigned DEF_IMG_H  = 8;

  // Width of a counter spanning 0..depth-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEF_COL_W = cnt_width(DEF_IMG_W);
  localparam int unsigned DEF_ROW_W = cnt_width(DEF_IMG_H);

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

  function automatic bit kernel_legal(input int unsigned k);
    return (k == 1) || (k == 3) || (k == 5) || (k == 7);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Fixed-depth, enable-gated pixel delay line; one image row of storage.
module conv_line_buffer #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_din,
  output logic [N-1:0] o_dout
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (i_en) begin
      r_mem[0] <= i_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream KxK valid-convolution window generator feeding ConvLayer_calc.
// Optional build macro: CONV_WIN_STRIDE2_EN (flag only even-offset windows).
module conv_window_gen
  import cnn_conv_pkg::*;
#(
  parameter int unsigned KERNEL = DEF_KERNEL,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 pix_in,
  input  logic                         pix_en,
  input  logic                         sof,
  output logic [KERNEL*KERNEL*N-1:0]   data2conv,
  output logic                         en_out
);

  localparam int unsigned CW  = cnt_width(IMG_W);
  localparam int unsigned RW  = cnt_width(IMG_H);
  localparam int unsigned KM1 = KERNEL - 1;

  if (!kernel_legal(KERNEL)) begin : g_bad_kernel
    $error("conv_window_gen: KERNEL must be 1, 3, 5 or 7");
  end
  if ((IMG_W < KERNEL) || (IMG_H < KERNEL)) begin : g_bad_image
    $error("conv_window_gen: image smaller than kernel");
  end

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_win_ok;
  logic          w_valid;
  logic          r_en_out;
  logic [N-1:0]  w_tap [KERNEL];
  logic [N-1:0]  r_win [KERNEL][KERNEL];

  // sof overrides the counters so the current pixel lands on (0,0).
  always_comb begin
    w_col = sof ? '0 : r_col;
    w_row = sof ? '0 : r_row;
  end

  if (KERNEL == 1) begin : g_k1_valid
    assign w_win_ok = 1'b1;
  end else begin : g_kn_valid
    assign w_win_ok = (w_col >= CW'(KM1)) && (w_row >= RW'(KM1));
  end

`ifdef CONV_WIN_STRIDE2_EN
  localparam logic KM1_LSB = 1'(KM1 % 2);
  assign w_valid = w_win_ok && (w_col[0] == KM1_LSB) && (w_row[0] == KM1_LSB);
`else
  assign w_valid = w_win_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_en_out <= 1'b0;
    end else begin
      r_en_out <= pix_en && w_valid;
      if (pix_en) begin
        if (w_col == CW'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  assign w_tap[0] = pix_in;

  for (genvar gk = 1; gk < KERNEL; gk++) begin : g_lb
    conv_line_buffer #(
      .N     (N),
      .DEPTH (IMG_W)
    ) u_lb (
      .clk    (clk),
      .rst    (rst),
      .i_en   (pix_en),
      .i_din  (w_tap[gk-1]),
      .o_dout (w_tap[gk])
    );
  end

  // Rows shift left every accepted pixel, even across row wraps; only the
  // validity flag decides which of those shifted windows are presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '{default: '0};
    end else if (pix_en) begin
      for (int unsigned r = 0; r < KERNEL; r++) begin
        for (int unsigned c = 0; c + 1 < KERNEL; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][KM1] <= w_tap[KM1-r];
      end
    end
  end

  for (genvar gr = 0; gr < KERNEL; gr++) begin : g_pack_r
    for (genvar gc = 0; gc < KERNEL; gc++) begin : g_pack_c
      assign data2conv[win_idx(gr, gc, KERNEL)*N +: N] = r_win[gr][gc];
    end
  end

  assign en_out = r_en_out;

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming KxK window generator that feeds `ConvLayer_calc`. It accepts one raster-order pixel per enabled cycle and buffers KERNEL-1 image rows in line buffers. Whenever a complete valid-convolution window (no padding) is available, it presents it on `data2conv` with a one-cycle `en_out` strobe. It is the transmitter side of the `data2conv`/`en_in` interface; `en_out` connects directly to the calc block's `en_in`.

## Interface
- `KERNEL`, 3: window side; legal values 1/3/5/7.
- `N`, 4: pixel width; must match the calc block's `N`.
- `IMG_W`, 8: image width in pixels; must be at least KERNEL.
- `IMG_H`, 8: image height in rows; must be at least KERNEL.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pix_in`  in  N  pixel value, unsigned.
- `pix_en`  in  1  `pix_in` is valid this cycle.
- `sof`  in  1  start of frame; sampled only when `pix_en`=1.
- `data2conv`  out  KERNEL\*KERNEL\*N  window. Element i=r\*KERNEL+c sits at `[i*N +: N]`. r=0 is the oldest row; c=0 is the oldest column.
- `en_out`  out  1  one-cycle strobe: `data2conv` holds a new valid window.

## Operation
- Counters:
  - `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1; both are `$clog2`-sized.
  - Each accepted pixel takes position (row,col). `col` then increments.
  - When `col` wraps to 0, `row` increments. When `row` wraps to 0 the frame is complete and the next pixel starts a new frame.
- `sof`=1 with `pix_en`=1 forces the current pixel to position (0,0), regardless of the counters. The counters then continue from (0,1). This abandons any partial frame.
- Line buffers:
  - There are KERNEL-1 cascaded row delays. Each is IMG_W deep and advances only on `pix_en`.
  - Tap k (k=0..KERNEL-1) is the pixel from k rows earlier. Tap 0 is `pix_in`.
- Window register:
  - On `pix_en`, each row of the window shifts one column toward c=0.
  - Column c=KERNEL-1 loads the taps: row r gets tap KERNEL-1-r.
  - Shifting continues across row boundaries. Windows that straddle a row boundary are never flagged.
- A window is valid when the accepted pixel has `col` ≥ KERNEL-1 and `row` ≥ KERNEL-1.
- `en_out` is asserted for exactly the cycle after a valid pixel is accepted.
- `data2conv` changes only in the cycle after a `pix_en`. It is otherwise held, including across `pix_en` gaps.
- `pix_en`=0: no state changes, and `en_out`=0.
- Line-buffer contents are not cleared between frames. Stale data never reaches a flagged window.
- KERNEL=1: there are no line buffers. `data2conv` equals the last `pix_in`, and every accepted pixel produces `en_out`.
- Each frame produces (IMG_W-KERNEL+1)\*(IMG_H-KERNEL+1) strobes.

## Timing
- Reset values: `en_out`=0, `data2conv`=0, counters=0, line buffers=0.
- Reset asserted mid-frame discards the frame. The first pixel after release is (0,0).
- Latency: a pixel accepted at edge t is in `data2conv[(KERNEL*KERNEL-1)*N +: N]` after edge t. `en_out` is high during the following cycle.
- Throughput: one pixel per cycle. There is no backpressure; the downstream block must accept every strobe.
- Simultaneous `sof` and the natural wrap to (0,0): identical result. Position (0,0) is never a valid window.

## Configuration
- `CONV_WIN_STRIDE2_EN` defined: a window is valid only if it also satisfies both conditions below. Per frame this gives ceil((IMG_W-KERNEL+1)/2)\*ceil((IMG_H-KERNEL+1)/2) strobes.
  - (`col`-(KERNEL-1)) is even.
  - (`row`-(KERNEL-1)) is even.
- `CONV_WIN_STRIDE2_EN` undefined: stride 1 as described above. No extra logic.

## Structure
- Shared package `cnn_conv_pkg` holds:
  - the window index function i=r\*KERNEL+c, also used by the weight packer;
  - the legal-KERNEL check;
  - the counter-width constants.
- One sub-module, `conv_line_buffer`: an IMG_W-deep, N-wide delay line with an enable. It is instantiated KERNEL-1 times with a generate loop.

## Test plan
Configuration unless stated: KERNEL=3, N=4, IMG_W=5, IMG_H=4. Pixels are driven with value = raster index mod 16, and `sof` is driven on the first pixel.
- **Basic:** the first `en_out` comes after pixel 12 (row 2, col 2). Window elements 0..8 must be 0,1,2,5,6,7,10,11,12.
- **Full frame:** exactly 6 strobes. The last window holds 7,8,9,12,13,14,17→1,18→2,19→3.
- **Gaps:** `pix_en` toggles 1/0 randomly. The windows and the 6 strobes match the gap-free run, and `data2conv` is stable during gaps.
- **Mid-frame events:**
  - `rst` pulsed after pixel 9, then a fresh frame: no `en_out` before its pixel 12, and all windows are correct.
  - `sof` pulsed at raster index 7 of a frame: the counters resync, and the first strobe follows the 13th pixel counted from the `sof` pixel.
- **KERNEL=1, IMG_W=IMG_H=2:** pixels 0..3 give 4 strobes, and `data2conv` = 0,1,2,3.
- **`CONV_WIN_STRIDE2_EN` defined:** 2 strobes, at (2,2) and (2,4). The windows are 0,1,2,5,6,7,10,11,12 and 2,3,4,7,8,9,12,13,14.
